// File: rtl/ibex_vector_filter_ctrl.sv
// ibex_vector_filter_ctrl
// Sequences one vector filter operation:
//   1. Accept a command.
//   2. Load three 128-bit operand registers in 32-bit beats.
//   3. Pulse the selected enable for one EXEC cycle.
//   4. Hold the captured result until the consumer takes it.
// Optional: define IBEX_VEC_FILT_PERF_CNT_EN to count completed non-error results.
module ibex_vector_filter_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [1:0]   cmd_op_i,
    input  logic [1:0]   cmd_vsew_i,
    input  logic [4:0]   cmd_vl_i,
    input  logic         cmd_custom_filt_i,
    input  logic         data_valid_i,
    output logic         data_ready_o,
    input  logic [31:0]  data_i,
    output logic [127:0] vreg1_o,
    output logic [127:0] vreg2_o,
    output logic [127:0] vreg3_o,
    output logic [1:0]   vsew_o,
    output logic [4:0]   vl_o,
    output logic [3:0]   operator_o,
    output logic         add_en_o,
    output logic         sub_en_o,
    output logic         mult_en_o,
    output logic         custom_filt_o,
    input  logic [7:0]   result_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [7:0]   res_data_o,
    output logic         res_err_o,
    input  logic         abort_i,
    output logic         busy_o,
    output logic [15:0]  perf_cnt_o
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t              state;
    logic [1:0]          op_q;
    logic [3:0]          beat_q;
    // Layout is [reg][word][bit], so beat k lands in vreg(k/4), word k%4.
    logic [2:0][3:0][31:0] vreg_q;

    // Command, load, execute and response sequencing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            op_q          <= '0;
            beat_q        <= '0;
            vreg_q        <= '0;
            vsew_o        <= '0;
            vl_o          <= '0;
            custom_filt_o <= 1'b0;
            res_data_o    <= '0;
            res_err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q          <= cmd_op_i;
                        vsew_o        <= cmd_vsew_i;
                        vl_o          <= cmd_vl_i;
                        custom_filt_o <= cmd_custom_filt_i;
                        vreg_q        <= '0;
                        beat_q        <= '0;
                        if (cmd_op_i == OP_RSV) begin
                            res_err_o  <= 1'b1;
                            res_data_o <= '0;
                            state      <= RESP;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // An abort beats a beat arriving in the same cycle.
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (data_valid_i) begin
                        vreg_q[beat_q[3:2]][beat_q[1:0]] <= data_i;
                        if (beat_q == 4'd11) begin
                            state <= EXEC;
                        end else if (custom_filt_o && beat_q == 4'd3) begin
                            // The custom filter has no second operand, so vreg2 stays zero.
                            beat_q <= 4'd8;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end
                end
                EXEC: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else begin
                        res_data_o <= result_i;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready_i) begin
                        res_err_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    // Handshakes and enables decode straight from the state register.
    assign cmd_ready_o  = (state == IDLE);
    assign data_ready_o = (state == LOAD);
    assign res_valid_o  = (state == RESP);
    assign busy_o       = (state != IDLE);
    assign add_en_o     = (state == EXEC) && (op_q == OP_ADD);
    assign sub_en_o     = (state == EXEC) && (op_q == OP_SUB);
    assign mult_en_o    = (state == EXEC) && (op_q == OP_MUL);
    assign operator_o   = {2'b00, op_q};
    assign vreg1_o      = vreg_q[0];
    assign vreg2_o      = vreg_q[1];
    assign vreg3_o      = vreg_q[2];

`ifdef IBEX_VEC_FILT_PERF_CNT_EN
    logic [15:0] perf_q;

    // Count results the consumer accepted, excluding error results.
    // The counter wraps from 0xFFFF to 0x0000.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (state == RESP && res_ready_i && !res_err_o) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cnt_o = perf_q;
`else
    assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_vector_filter_ctrl.sv
// Scoreboard bench for ibex_vector_filter_ctrl.
// The driver pushes expected results into a queue, and a negedge monitor checks them.
// The expected results come from a word-list model of the operand load.
module tb_ibex_vector_filter_ctrl;

    logic         clk_i, rst_i;
    logic         cmd_valid_i, cmd_ready_o;
    logic [1:0]   cmd_op_i, cmd_vsew_i;
    logic [4:0]   cmd_vl_i;
    logic         cmd_custom_filt_i;
    logic         data_valid_i, data_ready_o;
    logic [31:0]  data_i;
    logic [127:0] vreg1_o, vreg2_o, vreg3_o;
    logic [1:0]   vsew_o;
    logic [4:0]   vl_o;
    logic [3:0]   operator_o;
    logic         add_en_o, sub_en_o, mult_en_o, custom_filt_o;
    logic [7:0]   result_i;
    logic         res_valid_o, res_ready_i;
    logic [7:0]   res_data_o;
    logic         res_err_o;
    logic         abort_i, busy_o;
    logic [15:0]  perf_cnt_o;

    ibex_vector_filter_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_vsew_i(cmd_vsew_i), .cmd_vl_i(cmd_vl_i),
        .cmd_custom_filt_i(cmd_custom_filt_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .vreg1_o(vreg1_o), .vreg2_o(vreg2_o), .vreg3_o(vreg3_o),
        .vsew_o(vsew_o), .vl_o(vl_o), .operator_o(operator_o),
        .add_en_o(add_en_o), .sub_en_o(sub_en_o), .mult_en_o(mult_en_o),
        .custom_filt_o(custom_filt_o), .result_i(result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_err_o(res_err_o),
        .abort_i(abort_i), .busy_o(busy_o), .perf_cnt_o(perf_cnt_o)
    );

    typedef struct {
        logic [1:0]   op;
        logic         cf;
        logic [1:0]   vsew;
        logic [4:0]   vl;
        logic         err;
        logic [7:0]   data;
        int           beats;
        logic [127:0] v1, v2, v3;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   good = 0;
    bit   hold_rdy = 0;

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] en_of(input logic [1:0] op);
        case (op)
            2'b00:   return 3'b100;
            2'b01:   return 3'b010;
            2'b10:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Randomly back-pressure the result port unless a test holds it.
    initial begin
        res_ready_i = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!hold_rdy) res_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: track handshakes, check enables and pop results.
    initial begin
        int beats_seen = 0, en_cnt = 0, cmd_cyc = 0, last_cyc = 0;
        bit prev_rv = 0;
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_rv = 0;
            end else begin
                if (cmd_valid_i && cmd_ready_o) begin
                    beats_seen = 0;
                    en_cnt = 0;
                    cmd_cyc = cyc;
                end
                if (data_valid_i && data_ready_o) begin
                    beats_seen++;
                    last_cyc = cyc;
                end
                if (add_en_o || sub_en_o || mult_en_o) begin
                    en_cnt++;
                    if (exp_q.size() == 0) begin
                        check("enable_unexpected", 1, 0);
                    end else begin
                        e = exp_q[0];
                        check("enables", {add_en_o, sub_en_o, mult_en_o}, en_of(e.op));
                        check("operator", operator_o, {2'b00, e.op});
                        check("vreg1", vreg1_o, e.v1);
                        check("vreg2", vreg2_o, e.v2);
                        check("vreg3", vreg3_o, e.v3);
                        check("custom_filt", custom_filt_o, e.cf);
                        check("vsew", vsew_o, e.vsew);
                        check("vl", vl_o, e.vl);
                    end
                end
                if (res_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("res_valid_unexpected", 1, 0);
                    end else begin
                        e = exp_q[0];
                        if (!prev_rv) begin
                            check("latency", e.err ? cyc - cmd_cyc : cyc - last_cyc, e.err ? 1 : 2);
                        end
                        check("res_data", res_data_o, e.data);
                        check("res_err", res_err_o, e.err);
                        check("cmd_ready_in_resp", cmd_ready_o, 0);
                        if (res_ready_i) begin
                            void'(exp_q.pop_front());
                            check("beat_count", beats_seen, e.beats);
                            check("enable_pulses", en_cnt, e.err ? 0 : 1);
                            if (!e.err) good++;
                        end
                    end
                end
                prev_rv = res_valid_o;
            end
        end
    end

    task automatic wait_rdy(input int sel, output bit ok);
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk_i);
            if ((sel == 0) ? cmd_ready_o : data_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(sel == 0 ? "cmd_ready_timeout" : "data_ready_timeout", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !res_valid_o) begin
                done = 1;
                break;
            end
        end
        if (!done) check("idle_timeout", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic kill_checks(input bit by_rst);
        if (by_rst) begin
            check("rst_vreg1", vreg1_o, 0);
            check("rst_vreg3", vreg3_o, 0);
            check("rst_fields", {vsew_o, vl_o, operator_o, res_data_o}, 0);
            check("rst_flags", {add_en_o, sub_en_o, mult_en_o, res_valid_o,
                                res_err_o, busy_o, custom_filt_o, data_ready_o}, 0);
            check("rst_perf", perf_cnt_o, 0);
        end else begin
            check("abort_busy", busy_o, 0);
            check("abort_res_valid", res_valid_o, 0);
        end
    endtask

    // Issue one command; kill_at >= 0 aborts (or resets) on that load beat.
    task automatic do_op(input logic [1:0] op, input bit cf, input int kill_at, input bit kill_rst,
                         input bit use_pat, input logic [31:0] pat, input logic [7:0] res_fix,
                         input bit wait_done);
        exp_t e;
        logic [127:0] vr[3];
        logic [31:0] d;
        bit ok;
        int idx;

        for (int i = 0; i < 3; i++) vr[i] = '0;
        e.op = op;
        e.cf = cf;
        e.vsew = 2'($urandom);
        e.vl = 5'($urandom);
        e.err = (op == 2'b11);
        e.data = e.err ? 8'h00 : (use_pat ? res_fix : 8'($urandom));
        e.beats = e.err ? 0 : (cf ? 8 : 12);
        result_i = e.err ? 8'($urandom) | 8'h01 : e.data;
        cmd_op_i = op;
        cmd_vsew_i = e.vsew;
        cmd_vl_i = e.vl;
        cmd_custom_filt_i = cf;
        cmd_valid_i = 1;
        wait_rdy(0, ok);
        cmd_valid_i = 0;
        cmd_op_i = 2'($urandom);
        cmd_custom_filt_i = 1'($urandom);
        if (!ok) return;

        if (e.err) begin
            exp_q.push_back(e);
        end else begin
            idx = 0;
            for (int k = 0; k < 12; k++) begin
                if (cf && k >= 4 && k < 8) continue;
                if ($urandom_range(0, 3) == 0) begin
                    data_valid_i = 0;
                    @(posedge clk_i);
                    #1;
                end
                d = use_pat ? pat : $urandom;
                data_i = d;
                data_valid_i = 1;
                if (idx == kill_at && !kill_rst) abort_i = 1;
                wait_rdy(1, ok);
                data_valid_i = 0;
                abort_i = 0;
                if (!ok) return;
                if (idx == kill_at) begin
                    if (kill_rst) begin
                        rst_i = 1;
                        #1;
                        kill_checks(1);
                        @(posedge clk_i);
                        #1;
                        rst_i = 0;
                    end else begin
                        kill_checks(0);
                    end
                    check("cmd_ready_after_kill", cmd_ready_o, 1);
                    repeat (3) @(posedge clk_i);
                    #1;
                    check("no_result_after_kill", res_valid_o, 0);
                    return;
                end
                vr[k / 4][32 * (k % 4) +: 32] = d;
                idx++;
            end
            e.v1 = vr[0];
            e.v2 = vr[1];
            e.v3 = vr[2];
            exp_q.push_back(e);
        end
        if (wait_done) wait_idle();
    endtask

    initial begin
        logic [1:0] op;
        bit cf;
        int kill;

        rst_i = 0;
        cmd_valid_i = 0;
        cmd_op_i = 0;
        cmd_vsew_i = 0;
        cmd_vl_i = 0;
        cmd_custom_filt_i = 0;
        data_valid_i = 0;
        data_i = 0;
        result_i = 0;
        abort_i = 0;
        #2 rst_i = 1;
        #1;
        kill_checks(1);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        check("reset_cmd_ready", cmd_ready_o, 1);
        check("reset_busy", busy_o, 0);

        // Add with a fixed beat pattern and result.
        do_op(2'b00, 0, -1, 0, 1, 32'h01010101, 8'd9, 1);
        // Custom-filter multiply with an 8-beat load.
        do_op(2'b10, 1, -1, 0, 0, 0, 0, 1);
        // Reserved opcode.
        do_op(2'b11, 0, -1, 0, 0, 0, 0, 1);
        // Abort at beat 5, then a normal command.
        do_op(2'b01, 0, 5, 0, 0, 0, 0, 1);
        do_op(2'b00, 0, -1, 0, 0, 0, 0, 1);
        // Abort on the final beat.
        do_op(2'b10, 1, 7, 0, 0, 0, 0, 1);

        // Hold the result port for more than 10 cycles.
        hold_rdy = 1;
        res_ready_i = 0;
        do_op(2'b01, 0, -1, 0, 0, 0, 0, 0);
        repeat (12) @(posedge clk_i);
        #1;
        check("stall_res_valid", res_valid_o, 1);
        hold_rdy = 0;
        res_ready_i = 1;
        wait_idle();

        // Reset in the middle of a load.
        do_op(2'b00, 0, 4, 1, 0, 0, 0, 1);
        do_op(2'b10, 0, -1, 0, 0, 0, 0, 1);

        // Random commands.
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom);
            cf = 1'($urandom);
            kill = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, cf ? 7 : 11)) : -1;
            do_op(op, cf, kill, 0, 0, 0, 0, 1);
        end

`ifdef IBEX_VEC_FILT_PERF_CNT_EN
        check("perf_cnt", perf_cnt_o, 16'(good));
`else
        check("perf_cnt", perf_cnt_o, 0);
`endif
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_vector_filter_ctrl.md
IBEX_VECTOR_FILTER_CTRL -- requirements
Module: ibex_vector_filter_ctrl

Interface
REQ-001 SHALL have parameter: none; all widths fixed (3 operand regs x 128 bits, 32-bit load bus).
REQ-002 SHALL have ports: clk_i  in  1  clock; single clock domain, rising edge.
REQ-003 SHALL have ports: rst_i  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports: cmd_valid_i in 1, cmd_ready_o out 1  command handshake.
REQ-005 SHALL have ports: cmd_op_i in 2 (00 add, 01 sub, 10 mult, 11 reserved); cmd_vsew_i in 2; cmd_vl_i in 5; cmd_custom_filt_i in 1.
REQ-006 SHALL have ports: data_valid_i in 1, data_ready_o out 1, data_i in 32  operand load beats.
REQ-007 SHALL have ports: vreg1_o, vreg2_o, vreg3_o out 128 each; vsew_o out 2; vl_o out 5; operator_o out 4; add_en_o, sub_en_o, mult_en_o, custom_filt_o out 1  drive to vector logic unit.
REQ-008 SHALL have ports: result_i in 8  clamped RGB result from vector logic unit.
REQ-009 SHALL have ports: res_valid_o out 1, res_ready_i in 1, res_data_o out 8, res_err_o out 1  result handshake.
REQ-010 SHALL have ports: abort_i in 1 (synchronous cancel), busy_o out 1, perf_cnt_o out 16.

Function
REQ-011 SHALL implement FSM IDLE, LOAD, EXEC, RESP; busy_o=1 in any state except IDLE.
REQ-012 IDLE: cmd_ready_o=1; on cmd_valid_i latch op/vsew/vl/custom_filt, clear vreg1/2/3 to 0, beat counter to 0; op 11 -> RESP with res_err_o=1, res_data_o=0; else -> LOAD.
REQ-013 LOAD: data_ready_o=1; each accepted beat k (0..11) writes data_i to vreg(k/4+1)[32*(k%4)+31 : 32*(k%4)].
REQ-014 When latched custom_filt=1, beats 4..7 SHALL be skipped (counter jumps 3->8); load is 8 beats, vreg2_o stays 0.
REQ-015 After final beat accepted -> EXEC next cycle; data_valid_i outside LOAD SHALL be ignored (data_ready_o=0).
REQ-016 EXEC lasts exactly one cycle: exactly one of add_en_o/sub_en_o/mult_en_o =1 per latched op; operator_o = {2'b00, op}; result_i captured into res_data_o at end of EXEC; -> RESP.
REQ-017 Enables SHALL be 0 in every state except EXEC; vsew_o, vl_o, custom_filt_o, vreg*_o hold latched values until next accept.
REQ-018 RESP: res_valid_o=1, res_data_o/res_err_o stable until res_ready_i; on handshake -> IDLE, res_err_o cleared.
REQ-019 Latency: last load beat accepted at cycle N -> EXEC at N+1 -> res_valid_o at N+2.
REQ-020 cmd_ready_o=0 in all states but IDLE; no command queuing.
REQ-021 abort_i=1 in LOAD or EXEC -> IDLE next cycle, no result emitted, enables 0; abort_i ignored in IDLE and RESP.
REQ-022 abort_i and final load beat in same cycle: abort wins.

Reset
REQ-023 On rst_i (async assert): state IDLE; all vreg*_o, vsew_o, vl_o, operator_o, res_data_o = 0; all enables, res_valid_o, res_err_o, busy_o, custom_filt_o = 0; cmd_ready_o=1 after release; perf_cnt_o=0.
REQ-024 Reset mid-LOAD/EXEC/RESP SHALL discard the operation without emitting a result.

Configuration
REQ-025 Macro IBEX_VEC_FILT_PERF_CNT_EN defined: perf_cnt_o counts completed non-error RESP handshakes, 16-bit, wraps 0xFFFF->0x0000.
REQ-026 Macro undefined: perf_cnt_o tied 0, no counter flops.

Verification
REQ-027 Add op, custom_filt=0, 12 beats 0x01010101 (beat pattern), result_i=8'd9 -> add_en_o high exactly 1 cycle, res_data_o=9 two cycles after last beat.
REQ-028 custom_filt=1 mult, 8 beats -> exactly 8 data handshakes, vreg2_o=0, custom_filt_o=1, mult_en_o pulse once.
REQ-029 cmd_op_i=11 -> no LOAD beats accepted, res_valid_o next cycle with res_err_o=1, res_data_o=0.
REQ-030 abort_i at beat 5 -> IDLE next cycle, no res_valid_o, cmd_ready_o=1; following command completes normally.
REQ-031 res_ready_i held 0 for 10 cycles -> res_data_o stable, cmd_ready_o=0 throughout; rst_i mid-LOAD -> all outputs 0 immediately.
REQ-032 With IBEX_VEC_FILT_PERF_CNT_EN, 65536 good ops -> perf_cnt_o=0; error ops not counted.
